// File: rtl/leve_pkg.sv
// Shared definitions for the trap/mret CSR sequencer: FSM states, CSR addresses,
// mstatus bit positions and the CSR command encoding driven onto CMD.
// Latency: n/a (declarations only). Backpressure: n/a.
package leve_pkg;

  // Sequencer states: T_* walk the trap-entry CSR updates, R_* the mret path.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    T_EPC   = 4'd1,
    T_CAUSE = 4'd2,
    T_TVAL  = 4'd3,
    T_STAT  = 4'd4,
    T_VEC   = 4'd5,
    R_STAT  = 4'd6,
    R_EPC   = 4'd7,
    DONE    = 4'd8
  } state_e;

  // Command presented to the CSR file alongside CSR_A / CSR_WD.
  typedef enum logic [1:0] {
    CSR_NONE  = 2'd0,
    CSR_SET   = 2'd1,
    CSR_CLEAR = 2'd2,
    CSR_WRITE = 2'd3
  } csr_cmd_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/leve_trap_vec.sv
// Trap target computation from mtvec and the latched mcause value.
// Latency: purely combinational. Backpressure: none.
// Optional macro LEVE_TRAP_VECTORED_EN enables vectored mode for interrupts;
// without it mtvec[1:0] is ignored and the target is always the base.
// Ports: mtvec_i (mtvec read data), cause_i (latched mcause), target_o (fetch target).
module leve_trap_vec #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] cause_i,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] base;
  assign base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef LEVE_TRAP_VECTORED_EN
  logic            unused_cause;
  logic [XLEN-1:0] offset;

  // Only the low six cause bits select a vector slot; the sum wraps naturally.
  assign offset       = {{(XLEN-8){1'b0}}, cause_i[5:0], 2'b00};
  assign unused_cause = ^cause_i[XLEN-2:6];

  always_comb begin
    target_o = base;
    if (mtvec_i[1:0] == 2'b01 && cause_i[XLEN-1]) begin
      target_o = base + offset;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^{mtvec_i[1:0], cause_i};
  assign target_o    = base;
`endif

endmodule

// File: rtl/leve_trap_seq.sv
// Trap-entry / mret sequencer: walks mepc, mcause, mtval, mstatus and mtvec
// through the CSR port, one CSR per cycle, then pulses a fetch redirect.
// Latency: trap REDIRECT_VALID 6 cycles after acceptance (state DONE), mret 3.
// Backpressure: REQ_READY only in IDLE; requests arriving while BUSY are not
// accepted and must be held by the requester.
// Optional macro LEVE_TRAP_VECTORED_EN: vectored interrupt targets (see leve_trap_vec).
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   EXC_VALID/CAUSE/PC/TVAL  trap request and its mcause/pc/mtval payload
//   MRET_VALID          mret request
//   REQ_READY, BUSY     idle / sequencing status
//   CMD, CSR_A, CSR_WD  CSR file command, address, write data
//   CSR_RD              combinational CSR read data for CSR_A
//   REDIRECT_VALID/PC   one-cycle fetch redirect and its target
module leve_trap_seq
  import leve_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EXC_VALID,
  input  logic [XLEN-1:0] EXC_CAUSE,
  input  logic [XLEN-1:0] EXC_PC,
  input  logic [XLEN-1:0] EXC_TVAL,
  input  logic            MRET_VALID,
  output logic            REQ_READY,
  output logic [1:0]      CMD,
  output logic [11:0]     CSR_A,
  output logic [XLEN-1:0] CSR_WD,
  input  logic [XLEN-1:0] CSR_RD,
  output logic            REDIRECT_VALID,
  output logic [XLEN-1:0] REDIRECT_PC,
  output logic            BUSY
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] vec_target;

  // mepc is always written with bit 0 cleared, so the latched LSB is never read.
  logic unused_pc_lsb;
  assign unused_pc_lsb = pc_q[0];

  // mtvec is on CSR_RD while in T_VEC; cause comes from the latched request.
  leve_trap_vec #(
    .XLEN(XLEN)
  ) u_vec (
    .mtvec_i (CSR_RD),
    .cause_i (cause_q),
    .target_o(vec_target)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      cause_q    <= '0;
      tval_q     <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cause_q    <= cause_d;
      tval_q     <= tval_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cause_d    = cause_q;
    tval_d     = tval_q;
    redir_pc_d = redir_pc_q;
    CMD        = CSR_NONE;
    CSR_A      = '0;
    CSR_WD     = '0;

    case (state_q)
      IDLE: begin
        // A trap outranks a simultaneous mret; the mret stays pending upstream.
        if (EXC_VALID) begin
          pc_d    = EXC_PC;
          cause_d = EXC_CAUSE;
          tval_d  = EXC_TVAL;
          state_d = T_EPC;
        end else if (MRET_VALID) begin
          state_d = R_STAT;
        end
      end
      T_EPC: begin
        CMD     = CSR_WRITE;
        CSR_A   = CSR_MEPC;
        CSR_WD  = {pc_q[XLEN-1:1], 1'b0};
        state_d = T_CAUSE;
      end
      T_CAUSE: begin
        CMD     = CSR_WRITE;
        CSR_A   = CSR_MCAUSE;
        CSR_WD  = cause_q;
        state_d = T_TVAL;
      end
      T_TVAL: begin
        CMD     = CSR_WRITE;
        CSR_A   = CSR_MTVAL;
        CSR_WD  = tval_q;
        state_d = T_STAT;
      end
      T_STAT: begin
        // Read-modify-write of mstatus: stash MIE into MPIE, disable, enter M-mode.
        CMD                                   = CSR_WRITE;
        CSR_A                                 = CSR_MSTATUS;
        CSR_WD                                = CSR_RD;
        CSR_WD[MSTATUS_MPIE]                  = CSR_RD[MSTATUS_MIE];
        CSR_WD[MSTATUS_MIE]                   = 1'b0;
        CSR_WD[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        state_d                               = T_VEC;
      end
      T_VEC: begin
        CSR_A      = CSR_MTVEC;
        redir_pc_d = vec_target;
        state_d    = DONE;
      end
      R_STAT: begin
        // Restore MIE from MPIE, set MPIE, drop MPP to U.
        CMD                                   = CSR_WRITE;
        CSR_A                                 = CSR_MSTATUS;
        CSR_WD                                = CSR_RD;
        CSR_WD[MSTATUS_MIE]                   = CSR_RD[MSTATUS_MPIE];
        CSR_WD[MSTATUS_MPIE]                  = 1'b1;
        CSR_WD[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        state_d                               = R_EPC;
      end
      R_EPC: begin
        CSR_A      = CSR_MEPC;
        redir_pc_d = {CSR_RD[XLEN-1:1], 1'b0};
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign REQ_READY      = (state_q == IDLE);
  assign BUSY           = (state_q != IDLE);
  assign REDIRECT_VALID = (state_q == DONE);
  assign REDIRECT_PC    = redir_pc_q;

endmodule
